// File: rtl/muldiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_unit_pkg
//   Shared definitions for the iterative multiply/divide unit and the hazard
//   logic that tracks it: RV M-extension funct3 encodings, FSM state encoding
//   and operand-signedness decode helpers.
// -----------------------------------------------------------------------------
package muldiv_unit_pkg;

  // funct3 encodings of the M-extension ops
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  // Divide/remainder ops all have funct3[2] set.
  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // rs1 is treated as signed for MUL/MULH/MULHSU/DIV/REM.
  function automatic logic is_signed_a(input logic [2:0] op);
    logic s;
    case (op)
      OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM: s = 1'b1;
      default:                                   s = 1'b0;
    endcase
    return s;
  endfunction

  // rs2 is treated as signed for MUL/MULH/DIV/REM (not MULHSU).
  function automatic logic is_signed_b(input logic [2:0] op);
    logic s;
    case (op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: s = 1'b1;
      default:                         s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
//   One combinational radix-2 iteration on the {acc, q} register pair.
//   Multiply: add m to acc when q[0] is set, then shift {acc,q} right by one.
//   Divide  : shift {acc,q} left by one, trial-subtract m from the upper half,
//             keep the difference and shift in a 1 when it did not borrow.
// Ports
//   is_div   in   1     select divide step (else multiply step)
//   acc      in   XLEN  upper half (partial product / partial remainder)
//   q        in   XLEN  lower half (multiplier bits / dividend->quotient bits)
//   m        in   XLEN  multiplicand magnitude / divisor magnitude
//   acc_next out  XLEN  next upper half
//   q_next   out  XLEN  next lower half
// -----------------------------------------------------------------------------
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] q,
  input  logic [XLEN-1:0] m,
  output logic [XLEN-1:0] acc_next,
  output logic [XLEN-1:0] q_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic          fits;

  // Single add-shift or trial-subtract-shift iteration.
  always_comb begin
    sum      = {1'b0, acc} + (q[0] ? {1'b0, m} : {(XLEN+1){1'b0}});
    shifted  = {acc, q[XLEN-1]};
    // Remainder stays below the divisor, so a successful subtraction
    // always fits back into XLEN bits.
    fits     = (shifted >= {1'b0, m});
    acc_next = acc;
    q_next   = q;
    if (is_div) begin
      if (fits) begin
        acc_next = shifted[XLEN-1:0] - m;
        q_next   = {q[XLEN-2:0], 1'b1};
      end else begin
        acc_next = shifted[XLEN-1:0];
        q_next   = {q[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_next = sum[XLEN:1];
      q_next   = {sum[0], q[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative radix-2 multiply/divide unit for the RV M-extension. Accepts one
//   op per valid/ready handshake, runs XLEN iterations on operand magnitudes,
//   applies sign correction and special-case overrides, and holds the result
//   until the consumer takes it.
//   Optional macro MULDIV_EARLY_OUT_EN: div-by-zero, signed overflow and
//   multiplies with a zero operand skip the iteration phase (IDLE -> FIX).
// Ports
//   clk        in   1     core clock, rising edge
//   rst_n      in   1     asynchronous active-low reset
//   flush      in   1     synchronous kill of any in-flight or held op
//   in_valid   in   1     op/A/B valid
//   in_ready   out  1     unit can accept (IDLE)
//   op         in   3     funct3 of the M-extension op
//   A          in   XLEN  rs1 (multiplicand / dividend)
//   B          in   XLEN  rs2 (multiplier / divisor)
//   out_valid  out  1     O/Z/N valid
//   out_ready  in   1     consumer accepts result
//   O          out  XLEN  result
//   Z          out  1     O == 0
//   N          out  1     O[XLEN-1]
// -----------------------------------------------------------------------------
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] O,
  output logic            Z,
  output logic            N
);

  localparam int               CNT_W    = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   acc, q, m, a_orig;
  logic [2:0]        op_r;
  logic              sign_a, sign_b, div_zero, div_ovf, mul_zero;

  logic              accept, early_out;
  logic              in_div, in_sa, in_sb, in_ovf, in_mul_zero, in_div_zero;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN-1:0]   acc_step, q_step;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem, fix_res;

  assign in_ready = (state == S_IDLE);
  assign Z        = (O == {XLEN{1'b0}});
  assign N        = O[XLEN-1];

  // Operand decode at acceptance: signed ops iterate on magnitudes.
  assign accept      = in_valid & (state == S_IDLE) & ~flush;
  assign in_div      = is_div(op);
  assign in_sa       = is_signed_a(op) & A[XLEN-1];
  assign in_sb       = is_signed_b(op) & B[XLEN-1];
  assign mag_a       = in_sa ? -A : A;
  assign mag_b       = in_sb ? -B : B;
  assign in_div_zero = in_div & (B == {XLEN{1'b0}});
  assign in_ovf      = in_div & is_signed_a(op) & (A == MIN_VAL) & (B == {XLEN{1'b1}});
  assign in_mul_zero = ~in_div & ((A == {XLEN{1'b0}}) | (B == {XLEN{1'b0}}));

`ifdef MULDIV_EARLY_OUT_EN
  assign early_out = in_div_zero | in_ovf | in_mul_zero;
`else
  assign early_out = 1'b0;
`endif

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div   (is_div(op_r)),
    .acc      (acc),
    .q        (q),
    .m        (m),
    .acc_next (acc_step),
    .q_next   (q_step)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic; flush overrides everything.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) state_nxt = early_out ? S_FIX : S_CALC;
          else        state_nxt = S_IDLE;
        end
        S_CALC: begin
          if (cnt == LAST_CNT) state_nxt = S_FIX;
          else                 state_nxt = S_CALC;
        end
        S_FIX:   state_nxt = S_DONE;
        S_DONE: begin
          if (out_ready) state_nxt = S_IDLE;
          else           state_nxt = S_DONE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Sign correction, special-case override and hi/lo selection.
  always_comb begin
    if (sign_a ^ sign_b) begin
      prod = -{acc, q};
      quot = -q;
    end else begin
      prod = {acc, q};
      quot = q;
    end
    if (sign_a) rem = -acc;
    else        rem = acc;
    fix_res = {XLEN{1'b0}};
    case (op_r)
      OP_MUL: begin
        if (mul_zero) fix_res = {XLEN{1'b0}};
        else          fix_res = prod[XLEN-1:0];
      end
      OP_MULH, OP_MULHSU, OP_MULHU: begin
        if (mul_zero) fix_res = {XLEN{1'b0}};
        else          fix_res = prod[2*XLEN-1:XLEN];
      end
      OP_DIV, OP_DIVU: begin
        if (div_zero)     fix_res = {XLEN{1'b1}};
        else if (div_ovf) fix_res = MIN_VAL;
        else              fix_res = quot;
      end
      OP_REM, OP_REMU: begin
        if (div_zero)     fix_res = a_orig;
        else if (div_ovf) fix_res = {XLEN{1'b0}};
        else              fix_res = rem;
      end
      default: fix_res = {XLEN{1'b0}};
    endcase
  end

  // Datapath: operand latch, iteration, result register and out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= {CNT_W{1'b0}};
      acc       <= {XLEN{1'b0}};
      q         <= {XLEN{1'b0}};
      m         <= {XLEN{1'b0}};
      a_orig    <= {XLEN{1'b0}};
      op_r      <= 3'b000;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      div_zero  <= 1'b0;
      div_ovf   <= 1'b0;
      mul_zero  <= 1'b0;
      O         <= {XLEN{1'b0}};
      out_valid <= 1'b0;
    end else if (flush) begin
      // O deliberately keeps its last value.
      cnt       <= {CNT_W{1'b0}};
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt      <= {CNT_W{1'b0}};
            acc      <= {XLEN{1'b0}};
            q        <= in_div ? mag_a : mag_b;
            m        <= in_div ? mag_b : mag_a;
            a_orig   <= A;
            op_r     <= op;
            sign_a   <= in_sa;
            sign_b   <= in_sb;
            div_zero <= in_div_zero;
            div_ovf  <= in_ovf;
            mul_zero <= in_mul_zero;
          end
        end
        S_CALC: begin
          acc <= acc_step;
          q   <= q_step;
          cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        S_FIX: begin
          O         <= fix_res;
          out_valid <= 1'b1;
        end
        S_DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Self-checking bench for muldiv_unit (XLEN=32): directed vector table,
//   hand-written handshake/flush/reset sequences, and random ops checked
//   against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      op = 3'b000;
  logic [XLEN-1:0] A = '0;
  logic [XLEN-1:0] B = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] O;
  logic            Z;
  logic            N;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_o = 32'd0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .op(op), .A(A), .B(B), .out_valid(out_valid),
    .out_ready(out_ready), .O(O), .Z(Z), .N(N)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model straight from the M-extension arithmetic rules.
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    r  = 32'd0;
    case (o)
      OP_MUL:    begin p = sa * sb; r = p[31:0];  end
      OP_MULH:   begin p = sa * sb; r = p[63:32]; end
      OP_MULHSU: begin p = sa * ub; r = p[63:32]; end
      OP_MULHU:  begin p = ua * ub; r = p[63:32]; end
      OP_DIV: begin
        if (b == 32'd0) r = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
        else begin p = sa / sb; r = p[31:0]; end
      end
      OP_DIVU: begin
        if (b == 32'd0) r = 32'hFFFFFFFF;
        else begin p = ua / ub; r = p[31:0]; end
      end
      OP_REM: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'd0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: begin
        if (b == 32'd0) r = a;
        else begin p = ua % ub; r = p[31:0]; end
      end
    endcase
    return r;
  endfunction

  function automatic int exp_latency(input logic [2:0] o, input logic [31:0] a,
                                     input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    logic special;
    special = (o[2] && b == 32'd0) ||
              ((o == OP_DIV || o == OP_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF) ||
              (!o[2] && (a == 32'd0 || b == 32'd0));
    return special ? 1 : XLEN + 1;
`else
    return XLEN + 1;
`endif
  endfunction

  // Waits (bounded) for out_valid; k = edges after the acceptance edge.
  task automatic wait_out(output int k);
    k = 0;
    while (!out_valid && k < 200) begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end
  endtask

  task automatic do_op(input string name, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int hold);
    int k;
    @(negedge clk);
    op = o; A = a; B = b; in_valid = 1'b1;
    chk({name, " in_ready idle"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk({name, " in_ready busy"}, {31'd0, in_ready}, 32'd0);
    wait_out(k);
    chk({name, " latency"}, k, exp_latency(o, a, b));
    chk({name, " O"}, O, exp);
    chk({name, " Z"}, {31'd0, Z}, {31'd0, exp == 32'd0});
    chk({name, " N"}, {31'd0, N}, {31'd0, exp[31]});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({name, " hold O"}, O, exp);
      chk({name, " hold Z/N"}, {30'd0, Z, N}, {30'd0, exp == 32'd0, exp[31]});
      chk({name, " hold valid/ready"}, {30'd0, out_valid, in_ready}, 32'd2);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, " drain"}, {30'd0, out_valid, in_ready}, 32'd1);
    last_o = exp;
  endtask

  vec_t vecs[16];

  initial begin
    int k;
    logic seen;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    vecs[0]  = '{OP_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB};
    vecs[1]  = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[2]  = '{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000};
    vecs[3]  = '{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[4]  = '{OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD};
    vecs[5]  = '{OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF};
    vecs[6]  = '{OP_DIVU,   32'd100,      32'd7,        32'd14};
    vecs[7]  = '{OP_REMU,   32'd100,      32'd7,        32'd2};
    vecs[8]  = '{OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF};
    vecs[9]  = '{OP_REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9};
    vecs[10] = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[11] = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000};
    vecs[12] = '{OP_MUL,    32'h00000000, 32'h12345678, 32'h00000000};
    vecs[13] = '{OP_MULH,   32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFF};
    vecs[14] = '{OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD};
    vecs[15] = '{OP_REM,    32'd7,        32'hFFFFFFFE, 32'h00000001};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset out_valid/O", {31'd0, out_valid} | O, 32'd0);
    chk("reset Z/N", {30'd0, Z, N}, 32'd2);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 0);
    end

    // Hold result for 5 cycles with out_ready low
    do_op("hold", OP_MULHU, 32'h12345678, 32'h9ABCDEF0,
          ref_model(OP_MULHU, 32'h12345678, 32'h9ABCDEF0), 5);

    // No same-cycle accept on the drain edge
    @(negedge clk);
    op = OP_MUL; A = 32'd5; B = 32'd6; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(k);
    chk("drain first O", O, 32'd30);
    op = OP_MUL; A = 32'd3; B = 32'd4; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("drain no accept", {30'd0, out_valid, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("accept after drain", {31'd0, in_ready}, 32'd0);
    wait_out(k);
    chk("accept after drain O", O, 32'd12);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    last_o = 32'd12;

    // Flush at t+10 during CALC
    op = OP_DIVU; A = 32'd1000; B = 32'd3; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush idle", {30'd0, out_valid, in_ready}, 32'd1);
    chk("flush keeps O", O, last_o);
    seen = 1'b0;
    repeat (XLEN + 4) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("flush no out_valid", {31'd0, seen}, 32'd0);

    // flush together with in_valid in IDLE: not accepted
    op = OP_MUL; A = 32'd2; B = 32'd2; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("flush blocks accept", {31'd0, in_ready}, 32'd1);

    // Async reset mid-CALC
    do_op("pre-reset", OP_DIVU, 32'd100, 32'd7, 32'd14, 0);
    @(negedge clk);
    op = OP_DIV; A = 32'd77; B = 32'd5; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset O", O, 32'd0);
    chk("async reset flags", {29'd0, out_valid, Z, N}, 32'd2);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("post-reset mul", OP_MUL, 32'd3, 32'd4, 32'd12, 0);

    // Async reset while holding a result in DONE
    @(negedge clk);
    op = OP_MUL; A = 32'd9; B = 32'd9; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(k);
    chk("pre-reset done O", O, 32'd81);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset in DONE", {31'd0, out_valid} | O, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random ops against the reference model, biased towards corner operands
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0:       ra = 32'd0;
        1:       ra = 32'h80000000;
        2:       ra = 32'hFFFFFFFF;
        3:       ra = 32'($urandom_range(0, 20));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFFFFFF;
        2:       rb = 32'h80000000;
        3:       rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      do_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, ref_model(ro, ra, rb),
            int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
